// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller: checks load/store legality, drives
// the data memory with a bounded wait, and hands the raw read word downstream.
module dmem_access_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [31:0] address_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] write_data_i,
    output logic        busywait_o,
    output logic        dmem_read_o,
    output logic        dmem_write_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_byte_en_o,
    input  logic        dmem_busywait_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [31:0] rdata_word_o,
    output logic [1:0]  byte_offset_o,
    output logic [2:0]  funct3_out_o,
    output logic        load_valid_o,
    output logic        access_fault_o
);
    // state  | meaning
    // IDLE   | waiting for a request, legality checked here
    // ACCESS | strobes held, waiting for memory or timeout
    // DONE   | one-cycle completion, LOAD_VALID / ACCESS_FAULT pulse
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TIMEOUT);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rd_q, rd_d, wr_q, wr_d;
    logic [31:0]      addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]       be_q, be_d;
    logic [1:0]       off_q, off_d;
    logic [2:0]       f3_q, f3_d;
    logic             lv_q, lv_d, af_q, af_d;

    logic             any_req, f3_ok, align_ok, legal;
    logic [3:0]       be_req;
    logic [31:0]      wdata_req;

    always_comb begin
        any_req   = mem_read_i | mem_write_i;
        f3_ok     = 1'b0;
        align_ok  = 1'b0;
        be_req    = 4'b1111;
        wdata_req = write_data_i;
        case (funct3_i)
            3'b000: begin f3_ok = 1'b1;       align_ok = 1'b1; end
            3'b001: begin f3_ok = 1'b1;       align_ok = ~address_i[0]; end
            3'b010: begin f3_ok = 1'b1;       align_ok = (address_i[1:0] == 2'b00); end
            3'b100: begin f3_ok = mem_read_i; align_ok = 1'b1; end
            3'b101: begin f3_ok = mem_read_i; align_ok = ~address_i[0]; end
            default: ;
        endcase
        legal = (mem_read_i ^ mem_write_i) & f3_ok & align_ok;
        case (funct3_i[1:0])
            2'b00: begin
                be_req    = 4'b0001 << address_i[1:0];
                wdata_req = {4{write_data_i[7:0]}};
            end
            2'b01: begin
                be_req    = 4'b0011 << address_i[1:0];
                wdata_req = {2{write_data_i[15:0]}};
            end
            default: ;
        endcase
        if (mem_read_i) wdata_req = '0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        off_d   = off_q;
        f3_d    = f3_q;
        lv_d    = 1'b0;
        af_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    off_d = address_i[1:0];
                    f3_d  = funct3_i;
                    if (legal) begin
                        rd_d    = mem_read_i;
                        wr_d    = mem_write_i;
                        addr_d  = {address_i[31:2], 2'b00};
                        wdata_d = wdata_req;
                        be_d    = be_req;
                        cnt_d   = '0;
                        state_d = S_ACCESS;
                    end else begin
                        af_d    = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_ACCESS: begin
                if (!dmem_busywait_i) begin
                    if (rd_q) rdata_d = dmem_rdata_i;
                    lv_d    = rd_q;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_TC) begin
                    af_d    = 1'b1;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            off_q   <= '0;
            f3_q    <= '0;
            lv_q    <= 1'b0;
            af_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
            lv_q    <= lv_d;
            af_q    <= af_d;
        end
    end

    assign busywait_o     = ((state_q == S_IDLE) & any_req) | (state_q == S_ACCESS);
    assign dmem_read_o    = rd_q;
    assign dmem_write_o   = wr_q;
    assign dmem_addr_o    = addr_q;
    assign dmem_wdata_o   = wdata_q;
    assign dmem_byte_en_o = be_q;
    assign rdata_word_o   = rdata_q;
    assign byte_offset_o  = off_q;
    assign funct3_out_o   = f3_q;
    assign load_valid_o   = lv_q;
    assign access_fault_o = af_q;
endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Data-memory access controller for the MEM stage, sitting directly upstream of the data refine stage.
- Accepts load/store requests from the pipeline and checks alignment and FUNCT3 legality.
- Drives the data memory with word-aligned address, lane-replicated store data and byte enables, and waits out memory BUSYWAIT with a timeout.
- Hands the captured raw read word, byte offset and FUNCT3 to the refine stage.
- Stalls the pipeline via BUSYWAIT until the access completes or faults.

Parameters:
TIMEOUT, 255, max cycles spent in ACCESS before the access is aborted as a fault
CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET  input  1  asynchronous, active-low reset
MEM_READ  input  1  pipeline load request
MEM_WRITE  input  1  pipeline store request
ADDRESS  input  32  byte address from ALU
FUNCT3  input  3  access size/sign field
WRITE_DATA  input  32  store data from register file
BUSYWAIT  output  1  pipeline stall, combinational
DMEM_READ  output  1  memory read strobe, registered
DMEM_WRITE  output  1  memory write strobe, registered
DMEM_ADDR  output  32  word address {ADDRESS[31:2],2'b00}, registered
DMEM_WDATA  output  32  lane-replicated store data, registered
DMEM_BYTE_EN  output  4  byte lane enables, registered
DMEM_BUSYWAIT  input  1  memory busy
DMEM_RDATA  input  32  memory read word
RDATA_WORD  output  32  captured raw read word to refine stage, registered
BYTE_OFFSET  output  2  ADDRESS[1:0] of completed access, registered
FUNCT3_OUT  output  3  FUNCT3 of completed access, registered
LOAD_VALID  output  1  one-cycle pulse: RDATA_WORD valid for a completed load
ACCESS_FAULT  output  1  one-cycle pulse: illegal, misaligned or timed-out access

Behaviour:
- Reset (RESET=0, asynchronous):
  - State goes to IDLE and the counter clears.
  - All registered outputs go to 0.
  - A reset mid-access drops the request immediately; the strobes deassert at once.
- States: IDLE, ACCESS, DONE.
- Request: MEM_READ xor MEM_WRITE. The pipeline holds the request inputs stable while BUSYWAIT=1.
- Legality, checked in IDLE:
  - Loads: FUNCT3 ∈ {000,001,010,100,101}.
  - Stores: FUNCT3 ∈ {000,001,010}.
  - Halfword (001,101) requires ADDRESS[0]=0; word (010) requires ADDRESS[1:0]=00.
  - MEM_READ=MEM_WRITE=1 is illegal.
- Byte enables:
  - Byte: 4'b0001<<off.
  - Half: 4'b0011<<off.
  - Word: 4'b1111.
  - Driven for loads and stores alike.
- Store data:
  - Byte: {4{WRITE_DATA[7:0]}}.
  - Half: {2{WRITE_DATA[15:0]}}.
  - Word: WRITE_DATA.
  - DMEM_WDATA=0 for loads.
- IDLE:
  - Legal request: load DMEM_* registers, counter=0, go to ACCESS.
  - Illegal request: no memory strobe; latch BYTE_OFFSET/FUNCT3_OUT; go to DONE with fault.
  - No request: stay in IDLE.
- ACCESS:
  - Strobes are held.
  - DMEM_BUSYWAIT=0 sampled: capture DMEM_RDATA into RDATA_WORD (loads only), clear strobes, go to DONE. This gives a minimum of 1 ACCESS cycle.
  - Otherwise counter+1. When the counter reaches TIMEOUT with DMEM_BUSYWAIT still 1: clear strobes, go to DONE with fault; RDATA_WORD is unchanged.
- DONE (one cycle):
  - LOAD_VALID=1 for a successful load.
  - ACCESS_FAULT=1 for a faulted access.
  - Always go to IDLE next.
  - Request inputs present in DONE are ignored; the pipeline advances at the DONE edge.
- BUSYWAIT = (IDLE & request) | ACCESS. It is 0 in DONE and in idle with no request.
- Latency with memory ready on the first ACCESS cycle:
  - Request seen in cycle 0 (IDLE), ACCESS in cycle 1, DONE in cycle 2.
  - BUSYWAIT is high for 2 cycles.
- A fault latches BYTE_OFFSET/FUNCT3_OUT but never asserts LOAD_VALID. LOAD_VALID and ACCESS_FAULT are mutually exclusive.
- Back-to-back requests: a new request is evaluated in the IDLE cycle after DONE. There are no bubbles beyond DONE.

Test Plan:
- sw ADDRESS=0x104, WRITE_DATA=0xDEADBEEF, DMEM_BUSYWAIT=0 → DMEM_WRITE=1 one cycle, DMEM_ADDR=0x104, BYTE_EN=1111, WDATA=0xDEADBEEF; BUSYWAIT high 2 cycles; no LOAD_VALID.
- sb ADDRESS=0x203, WRITE_DATA=0x000000A5 → BYTE_EN=1000, WDATA=0xA5A5A5A5, DMEM_ADDR=0x200.
- lhu ADDRESS=0x302, DMEM_BUSYWAIT high 5 cycles, DMEM_RDATA=0x12345678 → RDATA_WORD=0x12345678, BYTE_OFFSET=2, FUNCT3_OUT=101, LOAD_VALID pulse 1 cycle after BUSYWAIT falls.
- lw ADDRESS=0x401 → no DMEM_READ, ACCESS_FAULT pulse, BUSYWAIT high 1 cycle; sh ADDRESS=0x1 and MEM_READ=MEM_WRITE=1 give the same response.
- TIMEOUT=4, DMEM_BUSYWAIT stuck high → strobes drop after 5 ACCESS cycles, ACCESS_FAULT pulse, RDATA_WORD unchanged.
- RESET driven low mid-ACCESS (asynchronous, between edges) → DMEM_READ=0 immediately, state IDLE; after release, a new lw completes normally.
